// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one async-FIFO write port among NREQ producers
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic [NREQ-1:0]            grant,
    output logic                       busy
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [OW-1:0] OWNER_LAST = OW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [OW-1:0]   last_q, last_d;
    logic [OW-1:0]   owner_q, owner_d;

    logic [OW-1:0]   sel;
    logic            found;
    logic            own_valid;
    logic            xfer;

    // Circular search starting just after the previous owner; the modulo keeps the index in range for any NREQ.
    always_comb begin
        int            idx;
        logic [OW-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(last_q) + k) % NREQ;
            cand = OW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign own_valid = |(req_valid & grant_q);
    assign xfer      = (state_q == GRANT) && own_valid && !wfull;
    assign winc      = xfer;
    assign req_ready = wfull ? '0 : grant_q;
    assign grant     = grant_q;
    assign busy      = (state_q == GRANT);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            burst_q <= '0;
            last_q  <= OWNER_LAST;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        last_d  = last_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = NREQ'(1) << sel;
                    burst_d = '0;
                    owner_d = sel;
                end
            end
            GRANT: begin
                // Owner dropping valid or hitting the burst limit both hand the port back through IDLE.
                if (!own_valid || (xfer && burst_q == BURST_LAST)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    burst_d = '0;
                    last_d  = owner_q;
                end else if (xfer) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter (4x4 directed, 3x2 random soak)
module tb_fifo_wr_arbiter;

    logic wclk = 1'b0;
    always #5 wclk = ~wclk;

    logic        wrst_a, wrst_b;
    logic [3:0]  valid_a, ready_a, grant_a;
    logic [31:0] data_a;
    logic        wfull_a, winc_a, busy_a;
    logic [7:0]  wdata_a;
    logic [2:0]  valid_b, ready_b, grant_b;
    logic [23:0] data_b;
    logic        wfull_b, winc_b, busy_b;
    logic [7:0]  wdata_b;

    fifo_wr_arbiter #(.NREQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_a (
        .wclk(wclk), .wrst_n(wrst_a), .req_valid(valid_a), .req_data(data_a),
        .req_ready(ready_a), .wfull(wfull_a), .winc(winc_a), .wdata(wdata_a),
        .grant(grant_a), .busy(busy_a)
    );

    fifo_wr_arbiter #(.NREQ(3), .DATA_WIDTH(8), .MAX_BURST(2)) dut_b (
        .wclk(wclk), .wrst_n(wrst_b), .req_valid(valid_b), .req_data(data_b),
        .req_ready(ready_b), .wfull(wfull_b), .winc(winc_b), .wdata(wdata_b),
        .grant(grant_b), .busy(busy_b)
    );

    typedef logic [7:0] word_q_t[$];
    word_q_t src_q[4];
    word_q_t exp_q[4];

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         use_b = 1'b0;
    int         nreq = 4;
    int         max_burst = 4;
    bit         rand_mode = 1'b0;
    bit         drop_mode = 1'b0;
    bit         full_in = 1'b0;
    bit         vld_r[4];
    int         drop_cnt[4];
    int         wait_cnt[4];
    logic [3:0] vv;
    logic [31:0] dd;
    logic [3:0] hs;
    int         t;
    logic [3:0] grant_tr[64];
    logic [3:0] rdy_tr[64];
    logic       winc_tr[64];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input int i, input logic [7:0] w);
        src_q[i].push_back(w);
        exp_q[i].push_back(w);
    endtask

    task automatic drive();
        vv = '0;
        dd = '0;
        for (int i = 0; i < nreq; i++) begin
            if (drop_cnt[i] > 0) drop_cnt[i]--;
            else if (!vld_r[i] && src_q[i].size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1))
                vld_r[i] = 1'b1;
            vv[i] = vld_r[i];
            if (vld_r[i]) dd[i*8 +: 8] = src_q[i][0];
        end
        if (use_b) begin
            valid_b = vv[2:0]; data_b = dd[23:0]; wfull_b = full_in;
            valid_a = '0;      data_a = '0;       wfull_a = 1'b0;
        end else begin
            valid_a = vv;      data_a = dd;       wfull_a = full_in;
            valid_b = '0;      data_b = '0;       wfull_b = 1'b0;
        end
    endtask

    task automatic monitor();
        logic [3:0] g, r;
        logic       wi, bz;
        logic [7:0] wd;
        int         o;
        if (use_b) begin
            g = {1'b0, grant_b}; r = {1'b0, ready_b}; wi = winc_b; bz = busy_b; wd = wdata_b;
        end else begin
            g = grant_a; r = ready_a; wi = winc_a; bz = busy_a; wd = wdata_a;
        end
        check_eq("grant_onehot0", $onehot0(g), 1);
        check_eq("ready_onehot0", $onehot0(r), 1);
        check_eq("busy_vs_grant", bz, g != 0);
        if (full_in) check_eq("winc_while_full", wi, 0);
        if (!bz) check_eq("ready_in_idle", r, 0);
        if (wi) begin
            o = 0;
            for (int i = 0; i < 4; i++) if (g[i]) o = i;
            if (exp_q[o].size() == 0) check_eq("unexpected_write", exp_q[o].size(), 1);
            else check_eq($sformatf("wdata_req%0d", o), wd, exp_q[o].pop_front());
        end
        hs = vv & r;
        for (int i = 0; i < nreq; i++) begin
            if (hs[i]) begin
                if (rand_mode) check_eq($sformatf("starve_req%0d", i),
                                        wait_cnt[i] > (nreq - 1) * (max_burst + 1), 0);
                wait_cnt[i] = 0;
            end else if (vld_r[i] && bz && !full_in) begin
                wait_cnt[i]++;
            end
        end
        if (t < 64) begin
            grant_tr[t] = g; rdy_tr[t] = r; winc_tr[t] = wi;
        end
    endtask

    task automatic update();
        for (int i = 0; i < nreq; i++) begin
            if (hs[i]) begin
                void'(src_q[i].pop_front());
                vld_r[i] = 1'b0;
                if (drop_mode) drop_cnt[i] = 1;
            end
        end
        t++;
    endtask

    task automatic tick();
        drive();
        #1;
        monitor();
        @(posedge wclk);
        #1;
        update();
    endtask

    task automatic drain(input string tag);
        int left;
        for (int c = 0; c < 300; c++) begin
            left = 0;
            for (int i = 0; i < nreq; i++) left += src_q[i].size();
            if (left == 0) break;
            tick();
        end
        tick();
        tick();
        left = 0;
        for (int i = 0; i < nreq; i++) left += exp_q[i].size();
        check_eq({"drain_", tag}, left, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete(); exp_q[i].delete();
            vld_r[i] = 1'b0; drop_cnt[i] = 0; wait_cnt[i] = 0;
        end
        hs = '0;
    endtask

    task automatic reset_a();
        wrst_a = 1'b0;
        @(posedge wclk);
        #1;
        wrst_a = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:9] ew1;
        logic [0:9] ew3;
        clear_model();
        vv = '0; dd = '0; t = 0;
        wrst_a = 1'b0; wrst_b = 1'b0;
        valid_a = 4'hF; data_a = 32'hA5A5A5A5; wfull_a = 1'b0;
        valid_b = '0;   data_b = '0;           wfull_b = 1'b0;
        #1;
        check_eq("rst_grant", grant_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_winc", winc_a, 0);
        check_eq("rst_ready", ready_a, 0);
        check_eq("rst_wdata", wdata_a, 0);
        repeat (2) @(posedge wclk);
        #1;
        wrst_a = 1'b1; wrst_b = 1'b1;

        // single requester, burst limit then regrant
        for (int k = 0; k < 6; k++) push_word(0, 8'h10 + 8'(k));
        t = 0;
        repeat (10) tick();
        ew1 = 10'b0111101100;
        for (int k = 0; k < 10; k++) check_eq($sformatf("t1_winc_c%0d", k), winc_tr[k], ew1[k]);
        check_eq("t1_grant_c4", grant_tr[4], 4'b0001);
        check_eq("t1_grant_c5", grant_tr[5], 4'b0000);
        check_eq("t1_grant_c6", grant_tr[6], 4'b0001);
        check_eq("t1_grant_c9", grant_tr[9], 4'b0000);
        drain("t1");

        // round robin with one word per grant
        reset_a();
        drop_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_word(i, 8'h20 + 8'(i * 2));
            push_word(i, 8'h21 + 8'(i * 2));
        end
        t = 0;
        repeat (14) tick();
        check_eq("t2_grant_c0", grant_tr[0], 4'b0000);
        check_eq("t2_grant_c1", grant_tr[1], 4'b0001);
        check_eq("t2_winc_c2", winc_tr[2], 1'b0);
        check_eq("t2_grant_c3", grant_tr[3], 4'b0000);
        check_eq("t2_grant_c4", grant_tr[4], 4'b0010);
        check_eq("t2_grant_c6", grant_tr[6], 4'b0000);
        check_eq("t2_grant_c7", grant_tr[7], 4'b0100);
        check_eq("t2_grant_c9", grant_tr[9], 4'b0000);
        check_eq("t2_grant_c10", grant_tr[10], 4'b1000);
        check_eq("t2_grant_c12", grant_tr[12], 4'b0000);
        check_eq("t2_grant_c13", grant_tr[13], 4'b0001);
        drain("t2");
        drop_mode = 1'b0;

        // full stall mid-burst
        for (int k = 0; k < 4; k++) push_word(2, 8'h40 + 8'(k));
        t = 0;
        for (int k = 0; k < 10; k++) begin
            full_in = (k >= 3 && k <= 5);
            tick();
        end
        full_in = 1'b0;
        ew3 = 10'b0110001100;
        for (int k = 0; k < 10; k++) check_eq($sformatf("t3_winc_c%0d", k), winc_tr[k], ew3[k]);
        for (int k = 3; k <= 5; k++) begin
            check_eq($sformatf("t3_ready_c%0d", k), rdy_tr[k], 4'b0000);
            check_eq($sformatf("t3_grant_c%0d", k), grant_tr[k], 4'b0100);
        end
        check_eq("t3_ready_c6", rdy_tr[6], 4'b0100);
        check_eq("t3_grant_c8", grant_tr[8], 4'b0000);
        drain("t3");

        // owner drops valid, search resumes after it
        push_word(1, 8'h51);
        t = 0;
        tick();
        push_word(0, 8'h60); push_word(0, 8'h61);
        push_word(3, 8'h70); push_word(3, 8'h71);
        repeat (5) tick();
        check_eq("t4_grant_c1", grant_tr[1], 4'b0010);
        check_eq("t4_winc_c1", winc_tr[1], 1'b1);
        check_eq("t4_grant_c2", grant_tr[2], 4'b0010);
        check_eq("t4_winc_c2", winc_tr[2], 1'b0);
        check_eq("t4_grant_c3", grant_tr[3], 4'b0000);
        check_eq("t4_grant_c4", grant_tr[4], 4'b1000);
        drain("t4");

        // asynchronous reset mid-burst
        for (int k = 0; k < 6; k++) push_word(0, 8'h80 + 8'(k));
        t = 0;
        repeat (3) tick();
        drive();
        #1;
        check_eq("t5_pre_winc", winc_a, 1'b1);
        wrst_a = 1'b0;
        #1;
        check_eq("t5_rst_grant", grant_a, 0);
        check_eq("t5_rst_winc", winc_a, 0);
        check_eq("t5_rst_ready", ready_a, 0);
        check_eq("t5_rst_busy", busy_a, 0);
        clear_model();
        @(posedge wclk);
        #1;
        wrst_a = 1'b1;
        push_word(0, 8'h90);
        push_word(3, 8'h93);
        t = 0;
        repeat (2) tick();
        check_eq("t5_grant_c0", grant_tr[0], 4'b0000);
        check_eq("t5_grant_c1", grant_tr[1], 4'b0001);
        drain("t5");

        // random soak on the 3-requester, burst-2 instance
        clear_model();
        use_b = 1'b1; nreq = 3; max_burst = 2; rand_mode = 1'b1;
        t = 0;
        for (int c = 0; c < 400; c++) begin
            int r;
            r = $urandom_range(0, 2);
            if (src_q[r].size() < 4) push_word(r, 8'($urandom));
            full_in = ($urandom_range(0, 3) == 0);
            tick();
        end
        full_in = 1'b0;
        rand_mode = 1'b0;
        drain("soak");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one async-FIFO write port among NREQ requesters in the write clock domain.
- Each requester has a valid/ready handshake; the block grants one requester at a time and forwards its data to the FIFO write port.
- Grants last for bounded bursts.
- Writes are throttled by the FIFO's registered full flag, so no write is attempted while full.
- Sits between write-domain producers and the FIFO write-pointer logic.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, FIFO word width
MAX_BURST, 4, max transfers per grant before forced release (>=1)

Ports:
wclk  input  1  write clock
wrst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester data valid
req_data  input  NREQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NREQ  per-requester ready; transfer when valid & ready
wfull  input  1  FIFO full flag (write domain, registered)
winc  output  1  FIFO write enable
wdata  output  DATA_WIDTH  FIFO write data
grant  output  NREQ  one-hot current owner, 0 when idle
busy  output  1  high in GRANT state

Behaviour:
Clock and reset:
- One clock, wclk.
- Reset is asynchronous and active-low on wrst_n.
- All state registers are cleared asynchronously.
- Reset values: state=IDLE, grant=0, burst_cnt=0, last_owner=NREQ-1 (so requester 0 has first priority).
- Outputs during and after reset: winc=0, req_ready=0, busy=0, wdata=0.

State machine (IDLE, GRANT):
- IDLE:
  - If any req_valid is high, select the first valid index searching circularly from last_owner+1.
  - Register grant=onehot(sel), burst_cnt=0, go to GRANT.
  - Arbitration latency is 1 cycle; no transfer occurs in IDLE.
  - If no req_valid is high, stay in IDLE.
- GRANT, owner o:
  - Combinational outputs: req_ready[o] = ~wfull; all other req_ready bits are 0.
  - winc = req_valid[o] & ~wfull.
  - wdata = req_data slice o, always (don't-care-safe when winc=0).
  - Transfer cycle (xfer = winc): burst_cnt increments.
  - Release 1: xfer with burst_cnt==MAX_BURST-1. Go to IDLE, last_owner=o, grant=0.
  - Release 2: req_valid[o]==0 in a GRANT cycle. Go to IDLE, last_owner=o, grant=0. No transfer occurs that cycle.
  - wfull=1 with req_valid[o]=1: hold GRANT, no transfer, burst_cnt unchanged. There is no timeout.
- After a release there is always exactly one IDLE cycle before the next grant, even if other requests are pending.
- A requester released on burst limit has lowest priority next round.

Width and arithmetic rules:
- burst_cnt is $clog2(MAX_BURST)+1 bits and never exceeds MAX_BURST-1 when registered.
- last_owner is $clog2(NREQ) bits. The circular search wraps modulo NREQ with no out-of-range index.
- Non-power-of-two NREQ is legal.

Invariants:
- grant is zero or one-hot.
- winc implies ~wfull.
- At most one req_ready bit is high.
- req_ready is never high in IDLE.
- Requests arriving during GRANT for a non-owner wait; they are not dropped. Requesters must hold valid and data until ready.

Reset mid-burst:
- Asynchronous return to reset values.
- The partially completed burst is not resumed.
- Words written before reset remain the FIFO's concern.

Test Plan:
1. MAX_BURST=4, only req0 valid with 6 words, wfull=0 -> winc high 4 cycles (words 0-3), 1 IDLE cycle, regrant req0, winc 2 cycles (words 4-5), then req0 drops valid -> IDLE.
2. All four requesters continuously valid, one word each burst (valid dropped after each accept) -> grant sequence 0001,0010,0100,1000,0001 with an IDLE cycle between each.
3. req2 granted, wfull asserted after 2 transfers for 3 cycles -> winc=0 and req_ready=0 for those 3 cycles, grant held, burst_cnt=2. On wfull=0 the remaining 2 words are written and the grant is released.
4. req1 owner drops valid after 1 transfer while req3 valid -> GRANT cycle with no winc, IDLE, then grant=1000. Search starts at index 2, so req3 wins over req0.
5. Assert wrst_n=0 mid-burst (burst_cnt=2) asynchronously -> grant, winc, req_ready, busy go to 0 immediately. After release with req0 and req3 valid, req0 is granted first.
6. Random valid/wfull soak, NREQ=3, MAX_BURST=2 -> scoreboard per-requester word order preserved, no winc while wfull, grant one-hot, no requester starved beyond (NREQ-1)*(MAX_BURST+1) non-full cycles.
